// File: rtl/cordic_pre_if.sv
// cordic_pre_if: sample/phase inputs and folded start-vector outputs of the CORDIC front end
interface cordic_pre_if #(
  parameter int DW = 20,
  parameter int AW = 20
);
  logic          pi_dv;
  logic          pi_phase_clr;
  logic [AW-1:0] pi_fcw;
  logic [DW-1:0] pi_x;
  logic [DW-1:0] pi_y;
  logic          po_dv;
  logic [AW+1:0] po_info;
  logic [DW-1:0] po_x;
  logic [DW-1:0] po_y;
  logic [AW-1:0] po_z;
  modport master (
    output pi_dv, pi_phase_clr, pi_fcw, pi_x, pi_y,
    input  po_dv, po_info, po_x, po_y, po_z
  );
  modport slave (
    input  pi_dv, pi_phase_clr, pi_fcw, pi_x, pi_y,
    output po_dv, po_info, po_x, po_y, po_z
  );
endinterface

// File: rtl/cordic_pre.sv
// cordic_pre: 2-stage CORDIC front end folding an NCO phase or an (x,y) sample into quadrant 1.
// Defining CORDIC_PRE_DITHER_EN adds LFSR phase dither to the NCO path.
module cordic_pre #(
  parameter string CORDIC_MODE = "NCO",
  parameter int    DW          = 20,
  parameter int    AW          = 20
) (
  input logic        clk,
  input logic        rst_n,
  cordic_pre_if.slave io
);
  localparam bit            is_angle = (CORDIC_MODE == "ANGLE");
  localparam logic [DW-1:0] smin     = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] smax     = ~smin;
  localparam logic [DW-1:0] unit     = {2'b01, {(DW-2){1'b0}}};
  localparam logic [AW-1:0] half     = {1'b1, {(AW-1){1'b0}}};
  logic [AW-1:0] acc, ph, ph_d;
  logic [DW-1:0] ax, ay;
  logic          s1_dv;
  logic [AW-1:0] s1_ph;
  logic [DW-1:0] s1_x, s1_y;
  logic [1:0]    s1_c;
  logic [1:0]    q, fc;
  logic [AW-1:0] fz;
  assign ph = io.pi_phase_clr ? '0 : acc;
`ifdef CORDIC_PRE_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk)
    if (!rst_n) lfsr <= 16'hACE1;
    else if (io.pi_dv) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign ph_d = ph + {{(AW-4){1'b0}}, lfsr[3:0]};
`else
  assign ph_d = ph;
`endif
  // magnitude saturates so the most negative input cannot wrap back to negative
  assign ax = io.pi_x[DW-1] ? ((io.pi_x == smin) ? smax : -io.pi_x) : io.pi_x;
  assign ay = io.pi_y[DW-1] ? ((io.pi_y == smin) ? smax : -io.pi_y) : io.pi_y;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      s1_dv <= 1'b0;
      s1_ph <= '0;
      s1_x  <= '0;
      s1_y  <= '0;
      s1_c  <= '0;
    end else begin
      s1_dv <= io.pi_dv;
      if (io.pi_dv) begin
        s1_ph <= is_angle ? '0 : ph_d;
        s1_x  <= ax;
        s1_y  <= ay;
        s1_c  <= {io.pi_x[DW-1], io.pi_y[DW-1]};
      end
      if (io.pi_dv) acc <= ph + io.pi_fcw;
      else if (io.pi_phase_clr) acc <= '0;
    end
  end
  // code bit1 negates x, bit0 negates y in the downstream post-correction
  assign q  = s1_ph[AW-1:AW-2];
  assign fc = {q[1] ^ q[0], q[1]};
  assign fz = (q == 2'b00) ? s1_ph :
              (q == 2'b01) ? half - s1_ph :
              (q == 2'b10) ? s1_ph - half : -s1_ph;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io.po_dv   <= 1'b0;
      io.po_x    <= '0;
      io.po_y    <= '0;
      io.po_z    <= '0;
      io.po_info <= '0;
    end else begin
      io.po_dv <= s1_dv;
      if (s1_dv) begin
        io.po_x    <= is_angle ? s1_x >> 1 : unit;
        io.po_y    <= is_angle ? s1_y >> 1 : '0;
        io.po_z    <= is_angle ? '0 : fz;
        io.po_info <= is_angle ? {s1_c, {AW{1'b0}}} : {fc, s1_ph};
      end
    end
  end
endmodule

// File: tb/tb_cordic_pre.sv
// tb_cordic_pre: directed checks of the NCO and ANGLE front ends at DW=AW=20
module tb_cordic_pre;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  cordic_pre_if #(.DW(20), .AW(20)) nco ();
  cordic_pre_if #(.DW(20), .AW(20)) ang ();
  cordic_pre #(.CORDIC_MODE("NCO"), .DW(20), .AW(20)) u_nco (.clk(clk), .rst_n(rst_n), .io(nco));
  cordic_pre #(.CORDIC_MODE("ANGLE"), .DW(20), .AW(20)) u_ang (.clk(clk), .rst_n(rst_n), .io(ang));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    nco.pi_dv = 1'b1; nco.pi_phase_clr = 1'b0; nco.pi_fcw = 20'd12345; nco.pi_x = '0; nco.pi_y = '0;
    ang.pi_dv = 1'b1; ang.pi_phase_clr = 1'b0; ang.pi_fcw = '0; ang.pi_x = -20'sd77; ang.pi_y = 20'sd99;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({nco.po_dv, nco.po_info, nco.po_x, nco.po_y, nco.po_z, ang.po_dv, ang.po_info, ang.po_x, ang.po_y, ang.po_z} !== '0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: nco dv=%b info=%h x=%h z=%h ang dv=%b x=%h y=%h, want all 0",
                 i, nco.po_dv, nco.po_info, nco.po_x, nco.po_z, ang.po_dv, ang.po_x, ang.po_y);
      end
    end
    rst_n = 1'b1;
    nco.pi_dv = 1'b0;
    ang.pi_dv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({nco.po_dv, nco.po_info, nco.po_x, nco.po_z, ang.po_dv, ang.po_x, ang.po_y} !== '0) begin
        n_bad++;
        $display("FAIL reset_release cyc%0d: nco dv=%b info=%h ang dv=%b x=%h, want all 0",
                 i, nco.po_dv, nco.po_info, ang.po_dv, ang.po_x);
      end
    end
  endtask
  task automatic test_nco_sweep();
    logic [19:0] ph, ez;
    logic [1:0]  ec;
    nco.pi_fcw = 20'd65536;
    nco.pi_dv  = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i == 17) nco.pi_dv = 1'b0;
      if (i >= 2) begin
        ph = 20'((i - 2) * 65536);
        n_cmp++;
        if ({nco.po_dv, nco.po_x, nco.po_y, nco.po_info[19:0]} !== {1'b1, 20'd262144, 20'd0, ph}) begin
          n_bad++;
          $display("FAIL nco_out%0d: dv=%b x=%0d y=%0d phase=%0d, want dv=1 x=262144 y=0 phase=%0d",
                   i - 1, nco.po_dv, nco.po_x, nco.po_y, nco.po_info[19:0], ph);
        end
      end
      if (i == 6 || i == 8 || i == 10 || i == 18) begin
        ez = (i == 6) ? 20'd262144 : (i == 8) ? 20'd131072 : 20'd0;
        ec = (i == 6 || i == 8) ? 2'b10 : (i == 10) ? 2'b11 : 2'b00;
        n_cmp++;
        if ({nco.po_info[21:20], nco.po_z} !== {ec, ez}) begin
          n_bad++;
          $display("FAIL nco_fold%0d: code=%b z=%0d, want code=%b z=%0d",
                   i - 1, nco.po_info[21:20], nco.po_z, ec, ez);
        end
      end
    end
  endtask
  task automatic test_phase_clr();
    logic [22:0] ex [4];
    logic [19:0] ez [4];
    ex[0] = {1'b1, 2'b00, 20'd0};      ez[0] = 20'd0;
    ex[1] = {1'b1, 2'b10, 20'd300000}; ez[1] = 20'd224288;
    ex[2] = {1'b1, 2'b00, 20'd0};      ez[2] = 20'd0;
    ex[3] = {1'b1, 2'b00, 20'd1000};   ez[3] = 20'd1000;
    nco.pi_phase_clr = 1'b1; nco.pi_dv = 1'b0;
    step();
    nco.pi_phase_clr = 1'b0; nco.pi_dv = 1'b1; nco.pi_fcw = 20'd300000;
    step();
    nco.pi_fcw = 20'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      nco.pi_phase_clr = (i == 0);
      nco.pi_fcw       = (i == 0) ? 20'd1000 : 20'd0;
      nco.pi_fcw       = (i == 1) ? 20'd1000 : nco.pi_fcw;
      nco.pi_dv        = (i < 2);
      n_cmp++;
      if ({nco.po_dv, nco.po_info, nco.po_z} !== ((i < 4) ? {ex[i], ez[i]} : {1'b0, ex[3][21:0], ez[3]})) begin
        n_bad++;
        $display("FAIL phase_clr%0d: dv=%b code=%b phase=%0d z=%0d, want %h",
                 i, nco.po_dv, nco.po_info[21:20], nco.po_info[19:0], nco.po_z,
                 (i < 4) ? {ex[i], ez[i]} : {1'b0, ex[3][21:0], ez[3]});
      end
    end
  endtask
  task automatic test_angle();
    logic [19:0] tx [5], ty [5], ex [5], ey [5];
    logic [1:0]  ec [5];
    tx = '{-20'sd1000, -20'sd524288, 20'sd0, 20'sd7, 20'sd10};
    ty = '{20'sd500, -20'sd1, 20'sd6, -20'sd8, -20'sd524288};
    ex = '{20'd500, 20'd262143, 20'd0, 20'd3, 20'd5};
    ey = '{20'd250, 20'd0, 20'd3, 20'd4, 20'd262143};
    ec = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b01};
    for (int i = 0; i < 5; i++) begin
      ang.pi_dv = 1'b1; ang.pi_x = tx[i]; ang.pi_y = ty[i];
      step();
      ang.pi_dv = 1'b0;
      step();
      n_cmp++;
      if ({ang.po_dv, ang.po_x, ang.po_y, ang.po_z, ang.po_info} !== {1'b1, ex[i], ey[i], 20'd0, ec[i], 20'd0}) begin
        n_bad++;
        $display("FAIL angle%0d: dv=%b x=%0d y=%0d z=%0d info=%h, want x=%0d y=%0d z=0 code=%b",
                 i, ang.po_dv, ang.po_x, ang.po_y, ang.po_z, ang.po_info, ex[i], ey[i], ec[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    bit          p [5];
    logic [19:0] ex, ey;
    logic        edv;
    int          t;
    p  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ex = 20'd5;
    ey = 20'd262143;
    for (int e = 1; e <= 7; e++) begin
      ang.pi_dv = (e - 1 < 5) ? p[e-1] : 1'b0;
      ang.pi_x  = 20'(20 * e);
      ang.pi_y  = 20'(-4 * e);
      step();
      if (e >= 2) begin
        t   = e - 2;
        edv = (t < 5) ? p[t] : 1'b0;
        if (edv) begin
          ex = 20'(10 * (t + 1));
          ey = 20'(2 * (t + 1));
        end
        n_cmp++;
        if ({ang.po_dv, ang.po_x, ang.po_y, ang.po_info[21:20]} !== {edv, ex, ey, 2'b01}) begin
          n_bad++;
          $display("FAIL gap_s%0d: dv=%b x=%0d y=%0d code=%b, want dv=%b x=%0d y=%0d code=01",
                   t, ang.po_dv, ang.po_x, ang.po_y, ang.po_info[21:20], edv, ex, ey);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_nco_sweep();
    test_phase_clr();
    test_angle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
